// File: rtl/firctl_pkg.sv
// Shared constants, state encoding and counter widths for the FIR control/input stage.
package firctl_pkg;

  localparam int NTAPS     = 4;
  localparam int COEF_W    = 8;
  localparam int COEF_BITS = NTAPS * COEF_W;
  localparam int SAMPLE_W  = 8;
  localparam int TAP_CNT_W = $clog2(NTAPS);
  localparam int BIT_CNT_W = $clog2(COEF_BITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_MAC,
    ST_COMMIT,
    ST_SHIFT,
    ST_FLUSH
  } firctl_state_t;

endpackage

// File: rtl/fir_sequencer_if.sv
// Handshake inputs and datapath control outputs of fir_sequencer.
// slave = the sequencer side, master = the upstream source / datapath side.
interface fir_sequencer_if;
  import firctl_pkg::*;

  logic [SAMPLE_W-1:0]  sampleIn;
  logic                 sampleValid;
  logic                 sampleReady;
  logic [COEF_BITS-1:0] coefWord;
  logic                 coefValid;
  logic                 coefReady;

  logic [SAMPLE_W-1:0]  a;
  logic [TAP_CNT_W-1:0] muxControl;
  logic                 clearAccum;
  logic                 dataEn;
  logic                 clearData;
  logic                 shiftEn;
  logic                 shiftIn;
  logic                 yValid;
  logic                 busy;

  modport slave (
    input  sampleIn, sampleValid, coefWord, coefValid,
    output sampleReady, coefReady, a, muxControl, clearAccum, dataEn,
           clearData, shiftEn, shiftIn, yValid, busy
  );

  modport master (
    output sampleIn, sampleValid, coefWord, coefValid,
    input  sampleReady, coefReady, a, muxControl, clearAccum, dataEn,
           clearData, shiftEn, shiftIn, yValid, busy
  );

endinterface

// File: rtl/firctl_piso.sv
// Coefficient serialiser: loads a 32-bit word and emits it MSB first while go_i is high.
// done_o flags the last bit so the sequencer can leave SHIFT on that edge.
module firctl_piso
  import firctl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic [COEF_BITS-1:0] word_i,
  input  logic                 go_i,
  output logic                 shift_en_o,
  output logic                 shift_in_o,
  output logic                 done_o
);

  logic [COEF_BITS-1:0] word_q, word_d;
  logic [BIT_CNT_W-1:0] count_q, count_d;
  logic [COEF_BITS-1:0] word_rev;

  // Bit-reversed view so the running count indexes bit 31 first.
  for (genvar gi = 0; gi < COEF_BITS; gi++) begin : g_rev
    assign word_rev[gi] = word_q[COEF_BITS-1-gi];
  end

  always_comb begin
    word_d  = word_q;
    count_d = count_q;
    if (load_i) begin
      word_d  = word_i;
      count_d = '0;
    end else if (go_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      count_q <= '0;
    end else begin
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

  assign shift_en_o = go_i;
  assign shift_in_o = go_i & word_rev[count_q];
  assign done_o     = go_i && (count_q == BIT_CNT_W'(COEF_BITS - 1));

endmodule

// File: rtl/fir_sequencer.sv
// Control and input stage for the 4-tap FIR datapath: sample pass sequencing and coefficient load.
// Define FIRCTL_RELOAD_CLEAR_EN to clear the delay line and y (FLUSH state) after every reload.
module fir_sequencer
  import firctl_pkg::*;
(
  input  logic            ph1,
  input  logic            reset_n,
  fir_sequencer_if.slave  bus
);

  firctl_state_t        state_q, state_d;
  logic [TAP_CNT_W-1:0] tap_q, tap_d;
  logic [SAMPLE_W-1:0]  a_q, a_d;
  logic                 yvalid_q, yvalid_d;
  logic                 clear_data_q;

  logic                 idle;
  logic                 coef_ready;
  logic                 sample_ready;
  logic                 sample_acc;
  logic                 coef_acc;
  logic                 piso_load;
  logic                 piso_go;
  logic                 piso_done;
  logic                 piso_shift_en;
  logic                 piso_shift_in;

  logic [TAP_CNT_W-1:0] mux_sel;
  logic                 clear_accum;
  logic                 data_en;
  logic                 clear_data;

  // Ready stays low until the first edge after reset, so every output other than clearData is 0 in reset.
  assign idle         = (state_q == ST_IDLE);
  assign coef_ready   = idle && !clear_data_q;
  assign sample_ready = coef_ready && !bus.coefValid;
  assign sample_acc   = bus.sampleValid && sample_ready;
  assign coef_acc     = bus.coefValid && coef_ready;
  assign piso_go      = (state_q == ST_SHIFT);

  firctl_piso u_piso (
    .clk        (ph1),
    .rst_n      (reset_n),
    .load_i     (piso_load),
    .word_i     (bus.coefWord),
    .go_i       (piso_go),
    .shift_en_o (piso_shift_en),
    .shift_in_o (piso_shift_in),
    .done_o     (piso_done)
  );

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    a_d       = a_q;
    yvalid_d  = 1'b0;
    piso_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (coef_acc) begin
          piso_load = 1'b1;
          state_d   = ST_SHIFT;
        end else if (sample_acc) begin
          a_d     = bus.sampleIn;
          state_d = ST_CLR;
        end
      end
      ST_CLR: begin
        tap_d   = '0;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        tap_d = tap_q + 1'b1;
        if (tap_q == TAP_CNT_W'(NTAPS - 1)) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        yvalid_d = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_SHIFT: begin
        if (piso_done) begin
`ifdef FIRCTL_RELOAD_CLEAR_EN
          state_d = ST_FLUSH;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    mux_sel     = '0;
    clear_accum = 1'b0;
    data_en     = 1'b0;
    clear_data  = clear_data_q;
    case (state_q)
      ST_CLR:    clear_accum = 1'b1;
      ST_MAC:    mux_sel     = tap_q;
      ST_COMMIT: begin
        mux_sel = TAP_CNT_W'(NTAPS - 1);
        data_en = 1'b1;
      end
      ST_FLUSH:  clear_data  = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge ph1 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      tap_q        <= '0;
      a_q          <= '0;
      yvalid_q     <= 1'b0;
      clear_data_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      a_q          <= a_d;
      yvalid_q     <= yvalid_d;
      clear_data_q <= 1'b0;
    end
  end

  assign bus.sampleReady = sample_ready;
  assign bus.coefReady   = coef_ready;
  assign bus.a           = a_q;
  assign bus.muxControl  = mux_sel;
  assign bus.clearAccum  = clear_accum;
  assign bus.dataEn      = data_en;
  assign bus.clearData   = clear_data;
  assign bus.shiftEn     = piso_shift_en;
  assign bus.shiftIn     = piso_shift_in;
  assign bus.yValid      = yvalid_q;
  assign bus.busy        = !idle;

endmodule

// File: tb/tb_fir_sequencer.sv
// Scoreboard bench for fir_sequencer: a behavioural FIR reference feeds expectation queues,
// and a monitor drives a datapath model from the DUT outputs and checks each result.
module tb_fir_sequencer;
  import firctl_pkg::*;

`ifdef FIRCTL_RELOAD_CLEAR_EN
  localparam int LOAD_CYCLES = 34;
`else
  localparam int LOAD_CYCLES = 33;
`endif
  localparam logic [18:0] RESET_OUTS = {1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fir_sequencer_if bus();
  fir_sequencer dut (
    .ph1     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int y;
    int cycle;
  } exp_t;

  exp_t        yq[$];
  logic [31:0] cq[$];
  int          hist[$];
  logic [31:0] ref_coefs = '0;
  logic [7:0]  last_a = '0;
  int          last_acc_cyc = 0;
  int          yvalid_seen = 0;

  logic [31:0] chain = '0;
  int          dly[3];
  int          acc = 0;
  int          y_dp = 0;
  int          mac_cnt = 0;
  int          shift_cnt = 0;
  exp_t        mon_e;
  logic [31:0] mon_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int coef_of(input logic [31:0] w, input int k);
    return int'((w >> (8 * k)) & 32'hFF);
  endfunction

  function automatic logic [18:0] outs();
    return {bus.sampleReady, bus.coefReady, bus.a, bus.muxControl, bus.clearAccum, bus.dataEn,
            bus.clearData, bus.shiftEn, bus.shiftIn, bus.yValid, bus.busy};
  endfunction

  // Reference: y[n] = sum c_k * x[n-k], history zero after reset (and after a reload with flush).
  task automatic model_sample(input logic [7:0] x, input int n);
    exp_t e;
    e.y = coef_of(ref_coefs, 0) * int'(x);
    for (int k = 1; k < 4; k++) begin
      if (k - 1 < hist.size()) e.y += coef_of(ref_coefs, k) * hist[k-1];
    end
    e.cycle = n + 7;
    yq.push_back(e);
    hist.push_front(int'(x));
    if (hist.size() > 3) void'(hist.pop_back());
    last_a = x;
    last_acc_cyc = n;
  endtask

  task automatic model_coef(input logic [31:0] w);
    ref_coefs = w;
    cq.push_back(w);
`ifdef FIRCTL_RELOAD_CLEAR_EN
    hist.delete();
`endif
  endtask

  // Monitor: datapath model driven purely by DUT control outputs, plus scoreboard pops.
  initial begin
    dly = '{0, 0, 0};
    forever begin
      @(negedge clk);
      if (!rst_n) shift_cnt = 0;
      if (bus.yValid) begin
        yvalid_seen++;
        if (yq.size() == 0) begin
          check("unexpected_yvalid", 1, 0);
        end else begin
          mon_e = yq.pop_front();
          $display("[TB] result y=%0d expected %0d at cycle %0d", y_dp, mon_e.y, cyc);
          check("y_result", y_dp, mon_e.y);
          check("yvalid_cycle", cyc, mon_e.cycle);
        end
      end
      if (bus.shiftEn) begin
        chain = {chain[30:0], bus.shiftIn};
        shift_cnt++;
      end else if (shift_cnt != 0) begin
        check("shift_count", shift_cnt, 32);
        if (cq.size() == 0) begin
          check("unexpected_coef_load", 1, 0);
        end else begin
          mon_w = cq.pop_front();
          $display("[TB] coef load chain='h%08h expected 'h%08h", chain, mon_w);
          check("coef_chain", chain, mon_w);
        end
        shift_cnt = 0;
      end
      if (int'(bus.clearAccum) + int'(bus.dataEn) + int'(bus.shiftEn) > 1)
        check("ctrl_exclusive", {bus.clearAccum, bus.dataEn, bus.shiftEn}, 0);
      if (bus.clearAccum) begin
        acc = 0;
        mac_cnt = 0;
      end else if (bus.busy && !bus.dataEn && !bus.shiftEn && !bus.clearData) begin
        check("mux_order", bus.muxControl, mac_cnt);
        acc += coef_of(chain, int'(bus.muxControl)) *
               ((bus.muxControl == 2'd0) ? int'(bus.a) : dly[int'(bus.muxControl) - 1]);
        mac_cnt++;
      end
      if (bus.dataEn) begin
        check("mac_cycles", mac_cnt, 4);
        check("a_stable", bus.a, last_a);
        y_dp = acc;
        dly[2] = dly[1];
        dly[1] = dly[0];
        dly[0] = int'(bus.a);
      end
      if (bus.clearData) begin
        dly = '{0, 0, 0};
        y_dp = 0;
      end
    end
  end

  task automatic send_samples(input logic [7:0] first, input int n, input bit chk_spacing);
    int got = 0;
    int waitc = 0;
    int prev = 0;
    @(posedge clk); #1;
    bus.sampleIn = first;
    bus.sampleValid = 1'b1;
    while (got < n) begin
      @(negedge clk);
      if (bus.sampleReady) begin
        if (chk_spacing && got > 0) check("accept_spacing", cyc - prev, 7);
        prev = cyc;
        model_sample(bus.sampleIn, cyc);
        got++;
        waitc = 0;
        @(posedge clk); #1;
        bus.sampleIn = 8'($urandom);
      end else begin
        waitc++;
        if (waitc > 100) begin
          check("sample_accept_timeout", 1, 0);
          break;
        end
      end
    end
    bus.sampleValid = 1'b0;
  endtask

  task automatic send_coef(input logic [31:0] w);
    int nc = 0;
    int waitc = 0;
    bit done = 0;
    @(posedge clk); #1;
    bus.coefWord = w;
    bus.coefValid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (bus.coefReady) begin
        model_coef(w);
        nc = cyc;
        done = 1;
      end else begin
        waitc++;
        if (waitc > 100) begin
          check("coef_accept_timeout", 1, 0);
          done = 1;
        end
      end
    end
    @(posedge clk); #1;
    bus.coefValid = 1'b0;
    done = 0;
    waitc = 0;
    while (!done) begin
      @(negedge clk);
      if (bus.coefReady) begin
        check("coef_ready_return", cyc - nc, LOAD_CYCLES);
        done = 1;
      end else begin
        waitc++;
        if (waitc > 100) begin
          check("coef_ready_timeout", 1, 0);
          done = 1;
        end
      end
    end
  endtask

  task automatic wait_idle();
    int waitc = 0;
    do begin
      @(negedge clk);
      waitc++;
    end while ((bus.busy || !bus.coefReady) && waitc < 100);
    if (waitc >= 100) check("idle_timeout", 1, 0);
  endtask

  task automatic send_both(input logic [31:0] w, input logic [7:0] x);
    int nc;
    int waitc = 0;
    bit done = 0;
    wait_idle();
    @(posedge clk); #1;
    bus.coefWord = w;
    bus.coefValid = 1'b1;
    bus.sampleIn = x;
    bus.sampleValid = 1'b1;
    @(negedge clk);
    check("both_sample_ready", bus.sampleReady, 0);
    check("both_coef_ready", bus.coefReady, 1);
    model_coef(w);
    nc = cyc;
    @(posedge clk); #1;
    bus.coefValid = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.sampleReady) begin
        check("sample_after_load", cyc - nc, LOAD_CYCLES);
        model_sample(bus.sampleIn, cyc);
        done = 1;
      end else begin
        waitc++;
        if (waitc > 100) begin
          check("deferred_sample_timeout", 1, 0);
          done = 1;
        end
      end
    end
    @(posedge clk); #1;
    bus.sampleValid = 1'b0;
  endtask

  task automatic drain();
    int waitc = 0;
    while ((yq.size() > 0 || cq.size() > 0) && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    check("drain_y", yq.size(), 0);
    check("drain_coef", cq.size(), 0);
  endtask

  initial begin
    int seen0;
    logic [13:0] exp_v;
    bus.sampleIn = '0;
    bus.sampleValid = 1'b0;
    bus.coefWord = '0;
    bus.coefValid = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), RESET_OUTS);
    rst_n = 1'b1;
    #1 check("clear_data_before_edge", bus.clearData, 1);
    @(negedge clk);
    check("release_clear_data", bus.clearData, 0);
    check("release_sample_ready", bus.sampleReady, 1);

    send_coef(32'h8001_00FF);

    // Single sample: per-cycle control sequence after the accept edge.
    send_samples(8'h05, 1, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      exp_v = {(i <= 6) ? 1'b1 : 1'b0, (i == 1) ? 1'b1 : 1'b0,
               (i >= 2 && i <= 5) ? 2'(i - 2) : ((i == 6) ? 2'd3 : 2'd0),
               (i == 6) ? 1'b1 : 1'b0, (i == 7) ? 1'b1 : 1'b0, 8'h05};
      check("pass_cycle", {bus.busy, bus.clearAccum, bus.muxControl, bus.dataEn, bus.yValid, bus.a}, exp_v);
    end

    seen0 = yvalid_seen;
    send_samples(8'($urandom), 3, 1'b1);
    drain();
    check("burst_yvalid_count", yvalid_seen - seen0, 3);

    send_both($urandom, 8'($urandom));
    drain();

    // Abort during the third MAC cycle.
    wait_idle();
    send_samples(8'($urandom), 1, 1'b0);
    repeat (4) @(negedge clk);
    check("abort_point_mux", bus.muxControl, 2);
    rst_n = 1'b0;
    yq.delete();
    hist.delete();
    #1 check("abort_reset_outputs", outs(), RESET_OUTS);
    seen0 = yvalid_seen;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("no_yvalid_after_abort", yvalid_seen - seen0, 0);

    for (int t = 0; t < 14; t++) begin
      if ($urandom_range(0, 3) == 0) send_coef($urandom);
      else send_samples(8'($urandom), int'($urandom_range(1, 3)), 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
